// File: rtl/psubsb_seq_if.sv
// Start/done handshake bundle for the sequential packed saturating subtractor.
// The master issues operands and start; the slave returns busy/done and the packed result.
interface psubsb_seq_if #(
    parameter int unsigned LaneW = 4,
    parameter int unsigned Lanes = 4
);
    localparam int unsigned DataW = LaneW * Lanes;

    logic             start;
    logic [DataW-1:0] A;
    logic [DataW-1:0] B;
    logic             busy;
    logic             done;
    logic [DataW-1:0] S;
    logic [Lanes-1:0] sat;

    modport master (output start, A, B, input busy, done, S, sat);
    modport slave  (input start, A, B, output busy, done, S, sat);
endinterface

// File: rtl/psubsb_seq.sv
// Packed signed saturating subtractor, one lane per cycle under a start/done handshake.
// Operands are latched at start, so the bus may change freely while busy.
module psubsb_seq #(
    parameter int unsigned LaneW = 4,
    parameter int unsigned Lanes = 4
) (
    input logic          clk,
    input logic          rst,
    psubsb_seq_if.slave  bus
);
    localparam int unsigned DataW = LaneW * Lanes;
    localparam int unsigned CntW  = (Lanes > 1) ? $clog2(Lanes) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [DataW-1:0] a_q, a_d;
    logic [DataW-1:0] b_q, b_d;
    logic [DataW-1:0] s_q, s_d;
    logic [Lanes-1:0] sat_q, sat_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    int unsigned      lane_lsb;
    logic [LaneW-1:0] a_l, b_l, d_l, r_l;
    logic             pos_ovf, neg_ovf;

    // Lane datapath: wrap-around difference, then clamp on signed overflow.
    always_comb begin
        lane_lsb = 32'(cnt_q) * LaneW;
        a_l      = a_q[lane_lsb +: LaneW];
        b_l      = b_q[lane_lsb +: LaneW];
        d_l      = a_l + ~b_l + LaneW'(1);
        pos_ovf  = ~a_l[LaneW-1] &  b_l[LaneW-1] &  d_l[LaneW-1];
        neg_ovf  =  a_l[LaneW-1] & ~b_l[LaneW-1] & ~d_l[LaneW-1];
        if (pos_ovf) begin
            r_l = {1'b0, {(LaneW-1){1'b1}}};
        end else if (neg_ovf) begin
            r_l = {1'b1, {(LaneW-1){1'b0}}};
        end else begin
            r_l = d_l;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        sat_d   = sat_q;
        unique case (state_q)
            StIdle, StDone: begin
                // DONE accepts start exactly like IDLE for back-to-back operation.
                if (bus.start) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    s_d     = '0;
                    sat_d   = '0;
                    cnt_d   = '0;
                    state_d = StBusy;
                end else begin
                    state_d = StIdle;
                end
            end
            StBusy: begin
                s_d[lane_lsb +: LaneW] = r_l;
                sat_d[cnt_q]           = pos_ovf | neg_ovf;
                cnt_d                  = cnt_q + CntW'(1);
                if (cnt_q == CntW'(Lanes - 1)) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d == StBusy);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            sat_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            sat_q   <= sat_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.S    = s_q;
    assign bus.sat  = sat_q;
endmodule

// File: tb/tb_psubsb_seq.sv
// Bench for psubsb_seq: directed and random operations, scoreboard checked on done.
module tb_psubsb_seq;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   cyc;
    bit   mon_en;

    typedef struct {
        logic [15:0] s;
        logic [3:0]  sat;
        int          e;
    } exp_t;

    exp_t exp_q[$];

    psubsb_seq_if #(.LaneW(4), .Lanes(4)) bus ();

    psubsb_seq #(.LaneW(4), .Lanes(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Reference: lane-wise signed difference clamped to [-8, 7].
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
        exp_t r;
        r.s   = '0;
        r.sat = '0;
        r.e   = 0;
        for (int i = 0; i < 4; i++) begin
            logic [3:0] al;
            logic [3:0] bl;
            int         d;
            al = a[i*4 +: 4];
            bl = b[i*4 +: 4];
            d  = int'($signed(al)) - int'($signed(bl));
            if (d > 7) begin
                d = 7;
                r.sat[i] = 1'b1;
            end else if (d < -8) begin
                d = -8;
                r.sat[i] = 1'b1;
            end
            r.s[i*4 +: 4] = 4'(d);
        end
        return r;
    endfunction

    // Called at posedge+#1; start is sampled at the next edge, done 4 edges after that.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input int hold);
        exp_t x;
        x   = model(a, b);
        x.e = cyc + 5;
        exp_q.push_back(x);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        @(posedge clk);
        #1;
        bus.A = 16'($urandom);
        bus.B = 16'($urandom);
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Monitor: checks busy every cycle and pops the scoreboard on done.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            logic bexp;
            bexp = 1'b0;
            if (exp_q.size() != 0) begin
                bexp = (cyc >= exp_q[0].e - 4) && (cyc <= exp_q[0].e - 1);
            end
            chk("busy", 32'(bus.busy), 32'(bexp));
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t x;
                    x = exp_q.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(x.e));
                    chk("S", 32'(bus.S), 32'(x.s));
                    chk("sat", 32'(bus.sat), 32'(x.sat));
                end
            end else if (exp_q.size() != 0 && exp_q[0].e <= cyc) begin
                chk("missing_done", 32'd0, 32'd1);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        total     = 0;
        bad       = 0;
        cyc       = 0;
        mon_en    = 1'b0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        #3;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_S", 32'(bus.S), 32'd0);
        chk("rst_sat", 32'(bus.sat), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        issue(16'h7531, 16'h1111, 0);
        drain();
        chk("hold_S", 32'(bus.S), 32'h6420);
        issue(16'h7777, 16'h8888, 0);
        drain();
        issue(16'h8888, 16'h1111, 0);
        drain();
        issue(16'h0000, 16'h0000, 0);
        drain();
        issue(16'h8270, 16'h1398, 0);
        drain();
        chk("mixed_sat_hold", 32'(bus.sat), 32'hB);

        // start held through all BUSY edges must not restart.
        issue(16'h7531, 16'h1111, 4);
        drain();
        repeat (3) @(posedge clk);
        #1;

        // Back-to-back: second start lands in DONE.
        issue(16'h7531, 16'h1111, 0);
        repeat (4) @(posedge clk);
        #1;
        issue(16'h0001, 16'h0002, 0);
        drain();

        // Async reset after lane 1 is written.
        issue(16'h7777, 16'h8888, 0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_done", 32'(bus.done), 32'd0);
        chk("arst_S", 32'(bus.S), 32'd0);
        chk("arst_sat", 32'(bus.sat), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        issue(16'h7531, 16'h1111, 0);
        drain();

        for (int i = 0; i < 40; i++) begin
            issue(16'($urandom), 16'($urandom), 0);
            if ($urandom_range(1, 0) == 1) begin
                repeat (4) @(posedge clk);
                #1;
            end else begin
                drain();
                repeat ($urandom_range(3, 0)) @(posedge clk);
                #1;
            end
        end
        drain();
        repeat (3) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/psubsb_seq.md
Name: psubsb_seq

Overview:
- Multi-cycle packed saturating subtractor: S = A - B on four independent signed 4-bit lanes, with saturation to the lane range.
- Processes one lane per cycle under a start/done handshake and reports a per-lane saturation flag.
- Sits in the execute stage beside the packed saturating adder; the pipeline stalls on busy.

Parameters:
- LANE_W, 4, bits per lane (signed two's complement).
- LANES, 4, number of lanes; data width = LANE_W*LANES = 16.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  request pulse; sampled only in IDLE or DONE.
- A  input  16  minuend, packed lanes; lane i = A[4i+3:4i].
- B  input  16  subtrahend, packed lanes.
- busy  output  1  high while lanes are being computed (state BUSY).
- done  output  1  one-cycle pulse; S and sat are valid while it is high and held afterwards.
- S  output  16  packed saturated differences.
- sat  output  4  sat[i]=1 if lane i saturated.

Behaviour:
- Reset (async, rst=1): state=IDLE, lane counter=0, busy=0, done=0, S=0, sat=0, operand registers=0. Takes effect immediately, including mid-operation; the in-flight operation is discarded.
- States: IDLE, BUSY, DONE. busy=1 only in BUSY; done=1 only in DONE; all outputs are registered.
- IDLE: if start=1 at an edge, latch A and B into operand registers, clear S and sat, set counter=0, then go to BUSY. Otherwise stay in IDLE.
- BUSY: at each edge, compute lane[counter] from the latched operands and write S lane and sat bit. Then increment the counter.
  - After the edge that writes lane 3, go to DONE.
  - start is ignored in BUSY.
  - Changes on A or B after acceptance have no effect.
- DONE: lasts one cycle, then goes to IDLE.
  - If start=1 in DONE, it is accepted exactly as in IDLE: operands are latched, S and sat are cleared, and the next state is BUSY. This gives back-to-back operation with no IDLE gap.
- Latency: start accepted at edge k; lanes 0..3 are written at edges k+1..k+4; done is high in the cycle following edge k+4 (5 cycles from start to done). Throughput is 1 operation per 5 cycles.
- Lane arithmetic: D = a + ~b + 1, truncated to 4 bits, where a and b are the lane values.
  - Positive overflow: a[3]=0, b[3]=1, D[3]=1. Result 4'b0111, sat bit=1.
  - Negative overflow: a[3]=1, b[3]=0, D[3]=0. Result 4'b1000, sat bit=1.
  - Otherwise: result D, sat bit=0.
- S is a partial result while busy=1 (unwritten lanes read 0). Consumers use S only when done=1 or later.
- S and sat hold their final values through IDLE until the next accepted start.
- Counter: 2 bits, wraps 3->0 on entry to DONE. It never indexes beyond lane 3.

Test Plan:
- Plain subtract: A=0x7531, B=0x1111, start 1 cycle -> done exactly 5 cycles later, S=0x6420, sat=4'b0000. busy is high for 4 cycles.
- Positive saturation: A=0x7777, B=0x8888 -> S=0x7777, sat=4'b1111.
- Negative saturation: A=0x8888, B=0x1111 -> S=0x8888, sat=4'b1111. Also A=0x0000, B=0x0000 -> S=0x0000, sat=0.
- Mixed lanes: A=0x8270, B=0x1398 -> S=0x8F77, sat=4'b1011. Changing A and B while busy does not alter the result.
- Handshake:
  - start held high during BUSY -> no restart; done appears once at the expected cycle.
  - start=1 during DONE with A=0x0001, B=0x0002 -> busy rises next cycle, then done 5 cycles after that start with S=0x000F, sat=0.
- Async reset mid-op: assert rst after lane 1 is written (between clock edges) -> busy=0, done=0, S=0x0000, sat=0 immediately, with no clock edge needed. Release rst, then start with A=0x7531, B=0x1111 -> S=0x6420 after 5 cycles.
